// File: rtl/fb_mem_arbiter.sv
// Shares the data-memory port between the CPU and a framebuffer prefetcher feeding a pixel FIFO.
// Optional ARB_STATS_EN adds stall-cycle and underflow counters.
module fb_mem_arbiter #(
    parameter logic [31:0] FB_BASE    = 32'h0000_1000,
    parameter int          FB_WORDS   = 307200,
    parameter int          FIFO_DEPTH = 16,
    parameter int          LOW_WM     = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_stall,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_frame_start,
    input  logic        i_px_rd,
    output logic [23:0] o_px_data,
    output logic        o_px_valid,
    output logic        o_underflow
`ifdef ARB_STATS_EN
    ,
    output logic [31:0] o_stall_cycles,
    output logic [15:0] o_underflow_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LOW_C     = CW'(LOW_WM);
    localparam logic [19:0]   LAST_PTR  = 20'(FB_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RUN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [19:0] r_fb_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [23:0] r_fifo [FIFO_DEPTH];
    logic        r_underflow;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_vga_grant;
    logic        w_cpu_grant;
    logic        w_low;
    logic        w_pop;
    logic        w_empty_pop;
    logic        w_last;
    logic [31:0] w_addr;

    assign w_low       = r_count < LOW_C;
    assign w_pop       = i_px_rd && (r_count != '0);
    assign w_empty_pop = i_px_rd && (r_count == '0);
    assign w_last      = r_fb_ptr == LAST_PTR;

    always_comb begin
        w_vga_grant = 1'b0;
        w_cpu_grant = 1'b0;
        case (r_state)
            S_REFILL, S_RUN: begin
                if (w_low)
                    w_vga_grant = 1'b1;
                else if (i_cpu_req)
                    w_cpu_grant = 1'b1;
                else
                    w_vga_grant = r_count < DEPTH_C;
            end
            default: w_cpu_grant = i_cpu_req;
        endcase
    end

    // REFILL and RUN arbitrate identically; REFILL only marks the initial fill.
    always_comb begin
        w_state_nxt = r_state;
        if (i_frame_start) begin
            w_state_nxt = S_REFILL;
        end else begin
            case (r_state)
                S_REFILL: begin
                    if (w_vga_grant && w_last)
                        w_state_nxt = S_DONE;
                    else if (!w_low)
                        w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (w_vga_grant && w_last)
                        w_state_nxt = S_DONE;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    assign w_addr = w_vga_grant ? (FB_BASE + {10'd0, r_fb_ptr, 2'b00}) : i_cpu_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fb_ptr    <= '0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_underflow <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_fifo[i] <= '0;
        end else begin
            if (w_vga_grant || w_cpu_grant)
                r_mem_addr <= w_addr;
            if (w_cpu_grant)
                r_mem_wdata <= i_cpu_wdata;
            if (w_empty_pop)
                r_underflow <= 1'b1;
            // Flush keeps the read pointer so px_data does not jump to a stale slot.
            if (i_frame_start) begin
                r_fb_ptr <= '0;
                r_count  <= '0;
                r_wr_ptr <= r_rd_ptr;
            end else begin
                if (w_vga_grant) begin
                    r_fifo[r_wr_ptr] <= i_mem_rdata[23:0];
                    r_wr_ptr         <= r_wr_ptr + AW'(1);
                    r_fb_ptr         <= r_fb_ptr + 20'd1;
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_vga_grant, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign o_cpu_rdata = i_mem_rdata;
    assign o_cpu_stall = i_cpu_req && !w_cpu_grant;
    assign o_mem_we    = w_cpu_grant && i_cpu_we;
    assign o_mem_addr  = (w_vga_grant || w_cpu_grant) ? w_addr : r_mem_addr;
    assign o_mem_wdata = w_cpu_grant ? i_cpu_wdata : r_mem_wdata;
    assign o_px_data   = r_fifo[r_rd_ptr];
    assign o_px_valid  = r_count != '0;
    assign o_underflow = r_underflow;

`ifdef ARB_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_underflow_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles  <= '0;
            r_underflow_cnt <= '0;
        end else if (i_frame_start) begin
            r_stall_cycles  <= '0;
            r_underflow_cnt <= '0;
        end else begin
            if (o_cpu_stall)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_empty_pop && (r_underflow_cnt != 16'hFFFF))
                r_underflow_cnt <= r_underflow_cnt + 16'd1;
        end
    end

    assign o_stall_cycles  = r_stall_cycles;
    assign o_underflow_cnt = r_underflow_cnt;
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: directed phases plus random traffic against a queue-based reference model.
module tb_fb_mem_arbiter;

    localparam logic [31:0] FB_BASE  = 32'h0000_1000;
    localparam int          FB_WORDS = 40;
    localparam int          DEPTH    = 16;
    localparam int          LOW_WM   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        frame_start, px_rd;
    logic [23:0] px_data;
    logic        px_valid, underflow;
`ifdef ARB_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] underflow_cnt;
`endif

    int checks = 0;
    int failures = 0;

    logic [23:0] q[$];
    bit          m_active;
    int          m_ptr;
    logic [31:0] m_last_addr, m_last_wdata;
    logic        m_under;
    bit          prev_stall;
    logic        h_req, h_we;
    logic [31:0] h_addr, h_wdata;

    function automatic logic [31:0] fmem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_5A3C;
    endfunction

    assign mem_rdata = fmem(mem_addr);

    always #5 clk = ~clk;

    fb_mem_arbiter #(
        .FB_BASE(FB_BASE), .FB_WORDS(FB_WORDS), .FIFO_DEPTH(DEPTH), .LOW_WM(LOW_WM)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .i_frame_start(frame_start), .i_px_rd(px_rd),
        .o_px_data(px_data), .o_px_valid(px_valid), .o_underflow(underflow)
`ifdef ARB_STATS_EN
        , .o_stall_cycles(stall_cycles), .o_underflow_cnt(underflow_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare 1ns later, then advance the model as the posedge will.
    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic fs, input logic rd);
        bit          vga, cpu, empty;
        int          lvl;
        logic [31:0] eaddr, word;
        @(negedge clk);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        frame_start = fs; px_rd = rd;
        #1;
        lvl   = q.size();
        vga   = m_active && (lvl < LOW_WM || (!req && lvl < DEPTH));
        cpu   = req && !vga;
        eaddr = vga ? FB_BASE + 32'(4 * m_ptr) : (cpu ? addr : m_last_addr);
        chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, req && !cpu});
        chk("mem_we", {31'd0, mem_we}, {31'd0, cpu && we});
        chk("mem_addr", mem_addr, eaddr);
        chk("mem_wdata", mem_wdata, cpu ? wdata : m_last_wdata);
        chk("cpu_rdata", cpu_rdata, fmem(eaddr));
        chk("px_valid", {31'd0, px_valid}, {31'd0, lvl != 0});
        if (lvl != 0) chk("px_data", {8'd0, px_data}, {8'd0, q[0]});
        chk("underflow", {31'd0, underflow}, {31'd0, m_under});
        prev_stall = req && !cpu;
        if (vga || cpu) m_last_addr = eaddr;
        if (cpu) m_last_wdata = wdata;
        empty = (lvl == 0);
        if (rd && empty) m_under = 1'b1;
        if (fs) begin
            q.delete();
            m_ptr    = 0;
            m_active = 1'b1;
        end else begin
            if (rd && !empty) void'(q.pop_front());
            if (vga) begin
                word = fmem(eaddr);
                q.push_back(word[23:0]);
                m_ptr++;
                if (m_ptr == FB_WORDS) m_active = 1'b0;
            end
        end
    endtask

    // CPU traffic that honours the hold-while-stalled rule.
    task automatic rnd_step(input int req_pct, input logic fs, input logic rd);
        if (!prev_stall) begin
            h_req   = ($urandom_range(0, 99) < req_pct);
            h_we    = $urandom_range(0, 1) == 1;
            h_addr  = {$urandom_range(0, 16'hFFFF), 2'b00};
            h_wdata = $urandom;
        end
        step(h_req, h_we, h_addr, h_wdata, fs, rd);
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; frame_start = 0; px_rd = 0;
        m_active = 0; m_ptr = 0; m_last_addr = 0; m_last_wdata = 0; m_under = 0; prev_stall = 0;
        h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_px_valid", {31'd0, px_valid}, 32'd0);
        chk("rst_underflow", {31'd0, underflow}, 32'd0);
        chk("rst_px_data", {8'd0, px_data}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // CPU alone before any frame
        repeat (20) step(1'b1, 1'b1, 32'h20, $urandom, 1'b0, 1'b0);

        // Fill to depth and pause
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (22) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Drain with CPU pressure: stall only below the watermark
        repeat (30) rnd_step(100, 1'b0, 1'b1);
        repeat (10) rnd_step(100, 1'b0, 1'b0);

        // Whole (short) frame, popping every cycle, then empty pops and CPU-only traffic
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (60) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        repeat (10) rnd_step(100, 1'b0, 1'b0);

        // Restart mid-frame at level 10; underflow must stay set
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++)
            rnd_step(50, ($urandom_range(0, 79) == 0), ($urandom_range(0, 2) != 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
